// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU step codes, flag indices, sequencer states and op encoding
package alu_pkg;

    // ALU FunSel[3:0] single-bit shift/rotate step codes
    localparam logic [3:0] FS_LSL = 4'b1011;
    localparam logic [3:0] FS_LSR = 4'b1100;
    localparam logic [3:0] FS_ASR = 4'b1101;
    localparam logic [3:0] FS_CSL = 4'b1110;
    localparam logic [3:0] FS_CSR = 4'b1111;

    // Bit positions inside the {Z,C,N,O} flag vector
    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_O = 0;

    // Request op encoding (5..7 fall back to LSL)
    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_LSR = 3'd1;
    localparam logic [2:0] OP_ASR = 3'd2;
    localparam logic [2:0] OP_CSL = 3'd3;
    localparam logic [2:0] OP_CSR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Map a request op onto the ALU step code it repeats
    function automatic logic [3:0] op_to_code(input logic [2:0] op);
        logic [3:0] code;
        case (op)
            OP_LSR:  code = FS_LSR;
            OP_ASR:  code = FS_ASR;
            OP_CSL:  code = FS_CSL;
            OP_CSR:  code = FS_CSR;
            default: code = FS_LSL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_shift_sequencer.sv
// rtl/alu_shift_sequencer.sv - multi-cycle shift/rotate sequencer driving the ALU one bit per cycle (optional Abort via ALU_SEQ_ABORT_EN)
module alu_shift_sequencer
    import alu_pkg::*;
#(
    parameter int AMT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
`ifdef ALU_SEQ_ABORT_EN
    input  logic             Abort,
`endif
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic             req_wide,
    input  logic [31:0]      req_data,
    input  logic [AMT_W-1:0] req_amount,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [3:0]       rsp_flags,
    output logic [31:0]      ALU_A,
    output logic [31:0]      ALU_B,
    output logic [4:0]       ALU_FunSel,
    output logic             ALU_WF,
    input  logic [31:0]      ALU_Out,
    input  logic [3:0]       ALU_Flags
);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      acc;
    logic [AMT_W-1:0] cnt;
    logic             wide_r;
    logic [3:0]       code_r;
    logic             accept;
    logic             abort_w;

    assign accept = (state == ST_IDLE) && req_valid;

`ifdef ALU_SEQ_ABORT_EN
    assign abort_w = Abort;
`else
    assign abort_w = 1'b0;
`endif

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand/result accumulator, step counter and latched step code
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc    <= 32'h0;
            cnt    <= '0;
            wide_r <= 1'b0;
            code_r <= 4'h0;
        end else if (accept) begin
            acc    <= req_wide ? req_data : {16'h0, req_data[15:0]};
            cnt    <= req_amount;
            wide_r <= req_wide;
            code_r <= op_to_code(req_op);
        end else if ((state == ST_SHIFT) && !abort_w) begin
            acc    <= ALU_Out;
            cnt    <= cnt - AMT_W'(1);
        end
    end

    // Next-state: zero-step requests skip straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = (req_amount == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort_w) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == AMT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: ALU is only driven and flag-written while stepping
    always_comb begin
        req_ready  = (state == ST_IDLE);
        rsp_valid  = (state == ST_DONE);
        rsp_data   = acc;
        rsp_flags  = ALU_Flags;
        ALU_A      = (state == ST_SHIFT) ? acc : 32'h0;
        ALU_B      = 32'h0;
        ALU_FunSel = {wide_r, code_r};
        ALU_WF     = (state == ST_SHIFT) && !abort_w;
    end

endmodule
